// File: rtl/fc_pkg.sv
// fc_pkg: shared FSM states, pipeline depth and quantize helpers for fc_engine
package fc_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, FINISH} fc_state_e;

    // cycles from the last issued word until its sum has landed in acc
    localparam int PIPE_DEPTH = 2;

    function automatic logic signed [63:0] sat_max(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

    // round-half-up arithmetic shift, saturate to dw bits, optional ReLU
    function automatic logic signed [63:0] fc_quantize(input logic signed [63:0] acc, input logic [7:0] sh,
                                                       input logic relu, input int dw);
        logic signed [63:0] t;
        t = (acc + ((sh == 8'd0) ? 64'sd0 : (64'sd1 <<< (sh - 8'd1)))) >>> sh;
        t = (t > sat_max(dw)) ? sat_max(dw) : (t < sat_min(dw)) ? sat_min(dw) : t;
        return (relu && t < 0) ? 64'sd0 : t;
    endfunction

endpackage

// File: rtl/fc_engine_mac_lanes.sv
// fc_mac_lanes: LANES signed multipliers, adder tree and stage-P sum register
//   act_i : LANES packed signed activations, lane 0 at LSBs
//   w_i   : LANES packed signed weights, lane 0 at LSBs
//   sum_o : registered sum of all lane products
module fc_mac_lanes #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 4,
    parameter int LANES        = 20,
    parameter int ACC_WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          srstn,
    input  logic [LANES*DATA_WIDTH-1:0]   act_i,
    input  logic [LANES*WEIGHT_WIDTH-1:0] w_i,
    output logic signed [ACC_WIDTH-1:0]   sum_o
);

    logic signed [DATA_WIDTH+WEIGHT_WIDTH-1:0] prod [LANES];
    logic signed [ACC_WIDTH-1:0]               sum_d;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            prod[i] = $signed(act_i[i*DATA_WIDTH +: DATA_WIDTH]) * $signed(w_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
            sum_d   = sum_d + ACC_WIDTH'(prod[i]);
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) sum_o <= '0;
        else        sum_o <= sum_d;
    end

endmodule

// File: rtl/fc_engine.sv
// fc_engine: fully-connected layer engine, one quantized byte per neuron
//   start/config   : in_len, out_len, a_base, w_base, o_base, shift, relu_en latched on accepted start
//   act/w SRAM     : act_raddr/act_rdata, w_raddr/w_rdata, 1-cycle read latency
//   output SRAM    : out_we, out_addr, out_data
//   status         : busy, done
//   FC_BIAS_EN     : adds b_base, b_raddr, b_rdata; acc is preloaded with the neuron bias
module fc_engine import fc_pkg::*; #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 4,
    parameter int LANES        = 20,
    parameter int ACC_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int WADDR_WIDTH  = 15,
    parameter int SHIFT_WIDTH  = 5
) (
    input  logic                          clk,
    input  logic                          srstn,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         in_len,
    input  logic [ADDR_WIDTH-1:0]         out_len,
    input  logic [ADDR_WIDTH-1:0]         a_base,
    input  logic [WADDR_WIDTH-1:0]        w_base,
    input  logic [ADDR_WIDTH-1:0]         o_base,
    input  logic [SHIFT_WIDTH-1:0]        shift,
    input  logic                          relu_en,
`ifdef FC_BIAS_EN
    input  logic [ADDR_WIDTH-1:0]         b_base,
    output logic [ADDR_WIDTH-1:0]         b_raddr,
    input  logic [ACC_WIDTH-1:0]          b_rdata,
`endif
    output logic [ADDR_WIDTH-1:0]         act_raddr,
    input  logic [LANES*DATA_WIDTH-1:0]   act_rdata,
    output logic [WADDR_WIDTH-1:0]        w_raddr,
    input  logic [LANES*WEIGHT_WIDTH-1:0] w_rdata,
    output logic                          out_we,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          busy,
    output logic                          done
);

    fc_state_e                   state_q, state_d;
    logic                        go_q, relu_q;
    logic [ADDR_WIDTH-1:0]       in_len_q, out_len_q, a_base_q, o_base_q, k_q, n_q;
    logic [WADDR_WIDTH-1:0]      w_ptr_q;
    logic [SHIFT_WIDTH-1:0]      shift_q;
    logic                        pv_q, pf_q, sv_q, sf_q;
    logic signed [ACC_WIDTH-1:0] sum_q, acc_q, first_sum;
    logic                        accept, last_k, drain_end;

    // start is accepted only from a quiet IDLE; the FSM acts on it one cycle later (go_q)
    assign accept    = start && state_q == IDLE && !go_q;
    assign last_k    = k_q == in_len_q - ADDR_WIDTH'(1);
    assign drain_end = k_q == ADDR_WIDTH'(PIPE_DEPTH - 1);

    fc_mac_lanes #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .LANES       (LANES),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_mac (
        .clk  (clk),
        .srstn(srstn),
        .act_i(act_rdata),
        .w_i  (w_rdata),
        .sum_o(sum_q)
    );

`ifdef FC_BIAS_EN
    logic [ADDR_WIDTH-1:0]       b_base_q;
    logic signed [ACC_WIDTH-1:0] bias_q;
    assign b_raddr   = b_base_q + n_q;
    assign first_sum = bias_q + sum_q;
`else
    assign first_sum = sum_q;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go_q) state_d = (in_len_q == '0 || out_len_q == '0) ? FINISH : ISSUE;
            ISSUE:   if (last_k) state_d = DRAIN;
            DRAIN:   if (drain_end) state_d = WRITE;
            WRITE:   state_d = (n_q == out_len_q - ADDR_WIDTH'(1)) ? FINISH : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            go_q      <= 1'b0;
            relu_q    <= 1'b0;
            in_len_q  <= '0;
            out_len_q <= '0;
            a_base_q  <= '0;
            o_base_q  <= '0;
            shift_q   <= '0;
            k_q       <= '0;
            n_q       <= '0;
            w_ptr_q   <= '0;
            pv_q      <= 1'b0;
            pf_q      <= 1'b0;
            sv_q      <= 1'b0;
            sf_q      <= 1'b0;
            acc_q     <= '0;
`ifdef FC_BIAS_EN
            b_base_q  <= '0;
            bias_q    <= '0;
`endif
        end else begin
            go_q <= accept;
            // valid/first flags ride alongside the read data (pv) and the stage-P sum (sv)
            pv_q <= state_q == ISSUE;
            pf_q <= k_q == '0;
            sv_q <= pv_q;
            sf_q <= pf_q;
            if (accept) begin
                in_len_q  <= in_len;
                out_len_q <= out_len;
                a_base_q  <= a_base;
                o_base_q  <= o_base;
                shift_q   <= shift;
                relu_q    <= relu_en;
                k_q       <= '0;
                n_q       <= '0;
                w_ptr_q   <= w_base;
`ifdef FC_BIAS_EN
                b_base_q  <= b_base;
`endif
            end
            // w_ptr runs straight through all neurons, so it equals w_base + n*in_len + k
            if (state_q == ISSUE) begin
                k_q     <= last_k ? '0 : k_q + ADDR_WIDTH'(1);
                w_ptr_q <= w_ptr_q + WADDR_WIDTH'(1);
            end
            if (state_q == DRAIN) k_q <= drain_end ? '0 : k_q + ADDR_WIDTH'(1);
            if (state_q == WRITE) n_q <= n_q + ADDR_WIDTH'(1);
`ifdef FC_BIAS_EN
            if (pv_q && pf_q) bias_q <= b_rdata;
`endif
            if (sv_q) acc_q <= sf_q ? first_sum : acc_q + sum_q;
        end
    end

    assign act_raddr = a_base_q + k_q;
    assign w_raddr   = w_ptr_q;
    assign out_we    = state_q == WRITE;
    assign out_addr  = o_base_q + n_q;
    assign out_data  = DATA_WIDTH'(fc_quantize(64'(acc_q), 8'(shift_q), relu_q, DATA_WIDTH));
    assign busy      = go_q || state_q inside {ISSUE, DRAIN, WRITE};
    assign done      = state_q == FINISH;

endmodule

// File: tb/tb_fc_engine.sv
// tb_fc_engine: scoreboard bench for fc_engine with behavioural SRAMs
module tb_fc_engine;

    logic         clk, srstn, start, relu_en;
    logic [9:0]   in_len, out_len, a_base, o_base, act_raddr, out_addr;
    logic [14:0]  w_base, w_raddr;
    logic [4:0]   shift;
    logic [159:0] act_rdata;
    logic [79:0]  w_rdata;
    logic         out_we, busy, done;
    logic [7:0]   out_data;

    logic [159:0] act_mem [1024];
    logic [79:0]  w_mem [32768];

`ifdef FC_BIAS_EN
    logic [9:0]  b_base, b_raddr;
    logic [31:0] b_rdata;
    logic [31:0] b_mem [1024];
    int          tb_bias;
    always @(posedge clk) b_rdata <= b_mem[b_raddr];
`endif

    fc_engine dut (
        .clk      (clk),
        .srstn    (srstn),
        .start    (start),
        .in_len   (in_len),
        .out_len  (out_len),
        .a_base   (a_base),
        .w_base   (w_base),
        .o_base   (o_base),
        .shift    (shift),
        .relu_en  (relu_en),
`ifdef FC_BIAS_EN
        .b_base   (b_base),
        .b_raddr  (b_raddr),
        .b_rdata  (b_rdata),
`endif
        .act_raddr(act_raddr),
        .act_rdata(act_rdata),
        .w_raddr  (w_raddr),
        .w_rdata  (w_rdata),
        .out_we   (out_we),
        .out_addr (out_addr),
        .out_data (out_data),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        act_rdata <= act_mem[act_raddr];
        w_rdata   <= w_mem[w_raddr];
    end

    int     n_chk, n_pass;
    longint exp_addr_q[$], exp_data_q[$];

    task automatic check(string tag, longint got, longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) if (srstn && out_we) begin
        if (exp_addr_q.size() == 0) check("unexpected_out_we", 1, 0);
        else begin
            check("out_addr", out_addr, exp_addr_q.pop_front());
            check("out_data", $signed(out_data), exp_data_q.pop_front());
        end
    end

    function automatic int get_a(int a, int l);
        logic signed [7:0] v;
        v = act_mem[a][l*8 +: 8];
        return int'(v);
    endfunction

    function automatic int get_w(int a, int l);
        logic signed [3:0] v;
        v = w_mem[a][l*4 +: 4];
        return int'(v);
    endfunction

    task automatic fill_act(int a, int v);
        for (int l = 0; l < 20; l++) act_mem[a % 1024][l*8 +: 8] = 8'(v);
    endtask

    task automatic fill_w(int a, int v);
        for (int l = 0; l < 20; l++) w_mem[a % 32768][l*4 +: 4] = 4'(v);
    endtask

    function automatic longint q_model(longint acc, int sh, bit relu);
        longint t;
        t = (sh == 0) ? acc : (acc + (longint'(1) << (sh - 1))) >>> sh;
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        if (relu && t < 0) t = 0;
        return t;
    endfunction

    // drives one layer from a negedge, pushes expected writes, checks timing and addresses per cycle
    task automatic run_layer(int il, int ol, int ab, int wb, int ob, int sh, bit relu, int restart_at);
        int     per, lat, r, n;
        longint acc;
        per = il + 3;
        lat = (il == 0 || ol == 0) ? 2 : ol * per + 2;
        if (il > 0 && ol > 0) for (int m = 0; m < ol; m++) begin
            acc = 0;
`ifdef FC_BIAS_EN
            b_mem[(ab + 7 + m) % 1024] = 32'(tb_bias);
            acc = tb_bias;
`endif
            for (int k = 0; k < il; k++)
                for (int l = 0; l < 20; l++)
                    acc += get_a((ab + k) % 1024, l) * get_w((wb + m * il + k) % 32768, l);
            exp_addr_q.push_back((ob + m) % 1024);
            exp_data_q.push_back(q_model(acc, sh, relu));
        end
        in_len  = 10'(il);
        out_len = 10'(ol);
        a_base  = 10'(ab);
        w_base  = 15'(wb);
        o_base  = 10'(ob);
        shift   = 5'(sh);
        relu_en = relu;
`ifdef FC_BIAS_EN
        b_base  = 10'(ab + 7);
`endif
        start = 1'b1;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (c == restart_at) begin
                in_len  = 10'(il + 1);
                out_len = 10'(ol + 2);
                o_base  = 10'(ob + 100);
            end
            check($sformatf("done_c%0d", c), done, c == lat);
            check($sformatf("busy_c%0d", c), busy, c < lat);
            if (il > 0 && ol > 0 && c >= 2) begin
                r = (c - 2) % per;
                n = (c - 2) / per;
                if (n < ol && r < il) begin
                    check("act_raddr", act_raddr, (ab + r) % 1024);
                    check("w_raddr", w_raddr, (wb + n * il + r) % 32768);
`ifdef FC_BIAS_EN
                    if (r == 0) check("b_raddr", b_raddr, (ab + 7 + n) % 1024);
`endif
                end
            end
        end
        start = 1'b0;
        check("writes_pending", exp_addr_q.size(), 0);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic check_zero_outputs(string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_out_we"}, out_we, 0);
        check({tag, "_act_raddr"}, act_raddr, 0);
        check({tag, "_w_raddr"}, w_raddr, 0);
        check({tag, "_out_addr"}, out_addr, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    initial begin
        bit seen;
        n_chk = 0;
        n_pass = 0;
        srstn = 1'b1;
        start = 1'b0;
        {in_len, out_len, a_base, o_base, w_base, shift, relu_en} = '0;
`ifdef FC_BIAS_EN
        b_base = '0;
        tb_bias = 0;
        for (int i = 0; i < 1024; i++) b_mem[i] = '0;
`endif
        for (int i = 0; i < 1024; i++) act_mem[i] = '0;
        for (int i = 0; i < 32768; i++) w_mem[i] = '0;
        #1 srstn = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        srstn = 1'b1;
        @(negedge clk);

        // all ones, one word, one neuron: 20, done at cycle 6
        fill_act(0, 1);
        fill_w(0, 1);
        run_layer(1, 1, 0, 0, 5, 0, 0, 0);

        // saturating layer with an ignored second start 5 cycles in
        for (int k = 0; k < 4; k++) fill_act(k, 127);
        for (int k = 0; k < 12; k++) fill_w(k, 7);
        run_layer(4, 3, 0, 0, 10, 0, 0, 5);

        // rounding, negative shift and ReLU
        fill_act(100, -15);
        fill_w(200, 1);
        run_layer(1, 1, 100, 200, 20, 2, 0, 0);
        run_layer(1, 1, 100, 200, 20, 2, 1, 0);
        for (int l = 0; l < 20; l++) act_mem[101][l*8 +: 8] = (l < 6) ? 8'd1 : 8'd0;
        fill_w(201, 1);
        run_layer(1, 1, 101, 201, 21, 2, 0, 0);

        // empty layers finish 2 cycles after start with no writes
        run_layer(0, 3, 0, 0, 30, 0, 0, 0);
        run_layer(2, 0, 0, 0, 30, 0, 0, 0);

        // reset mid-ISSUE aborts the layer
        for (int k = 0; k < 4; k++) fill_act(400 + k, 1);
        for (int k = 0; k < 8; k++) fill_w(2000 + k, 1);
        in_len = 10'd4;
        out_len = 10'd2;
        a_base = 10'd400;
        w_base = 15'd2000;
        o_base = 10'd60;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        srstn = 1'b0;
        #1 check_zero_outputs("abort");
        @(negedge clk);
        srstn = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= done;
        end
        check("abort_no_done", seen, 0);

        // random layers with address wrap on every SRAM
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < 5; k++)
                for (int l = 0; l < 20; l++) act_mem[(1021 + k) % 1024][l*8 +: 8] = 8'($urandom_range(255));
            for (int k = 0; k < 20; k++)
                for (int l = 0; l < 20; l++) w_mem[(32760 + k) % 32768][l*4 +: 4] = 4'($urandom_range(15));
            run_layer(5, 4, 1021, 32760, 1022, 7 - 3 * t, t == 0, 0);
        end

`ifdef FC_BIAS_EN
        // bias cancels the all-ones sum
        fill_act(0, 1);
        fill_w(0, 1);
        tb_bias = -20;
        run_layer(1, 1, 0, 0, 5, 0, 0, 0);
        tb_bias = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fc_engine.md
Name: fc_engine

Overview:
- Parametrised fully-connected layer engine; successor to the fixed FC1/FC2 datapath.
- Computes out_len neurons. Each neuron is a dot product over in_len words, each word being LANES activation/weight pairs.
- Per-neuron post-processing: configurable shift, rounding, saturation and ReLU.
- Reads the activation SRAM and weight SRAM with 1-cycle read latency; writes one quantized byte per neuron to the output SRAM.
- Started by a layer-done pulse from the upstream stage (conv or a previous fc_engine).

Parameters:
- DATA_WIDTH, 8, activation/output width, signed
- WEIGHT_WIDTH, 4, weight width, signed
- LANES, 20, pairs multiplied per cycle
- ACC_WIDTH, 32, accumulator width, signed; must be ≥ DATA_WIDTH+WEIGHT_WIDTH+clog2(LANES)+clog2(max in_len)
- ADDR_WIDTH, 10, activation/output SRAM address width
- WADDR_WIDTH, 15, weight SRAM address width
- SHIFT_WIDTH, 5, quantize shift field width

Ports:
- clk  in  1  clock
- srstn  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse; latches config and begins layer
- in_len  in  ADDR_WIDTH  words per neuron
- out_len  in  ADDR_WIDTH  neuron count
- a_base  in  ADDR_WIDTH  activation start address
- w_base  in  WADDR_WIDTH  weight start address
- o_base  in  ADDR_WIDTH  output start address
- shift  in  SHIFT_WIDTH  arithmetic right-shift amount
- relu_en  in  1  clamp negatives to 0
- act_raddr  out  ADDR_WIDTH  activation read address
- act_rdata  in  LANES*DATA_WIDTH  activation data, lane 0 at LSBs
- w_raddr  out  WADDR_WIDTH  weight read address
- w_rdata  in  LANES*WEIGHT_WIDTH  weight data, lane 0 at LSBs
- out_we  out  1  output write strobe
- out_addr  out  ADDR_WIDTH  output address
- out_data  out  DATA_WIDTH  quantized result
- busy  out  1  high from the cycle after start until done
- done  out  1  1-cycle completion pulse

Behaviour:
- Reset (async, srstn=0): all outputs 0, state IDLE, counters and accumulator 0.
- Config (in_len, out_len, bases, shift, relu_en) is latched on accepted start; it is ignored while busy.
- start while busy is ignored and does not restart the layer.
- FSM states: IDLE, ISSUE, DRAIN, WRITE, FINISH.
- IDLE:
  - on start with in_len=0 or out_len=0 → FINISH, no writes;
  - otherwise → ISSUE.
- ISSUE:
  - drives act_raddr = a_base+k and w_raddr = w_base + n*in_len + k, for k = 0..in_len-1 on consecutive cycles;
  - w_raddr is a single running counter, never a multiplier;
  - after k = in_len-1 → DRAIN.
- Pipeline:
  - rdata valid 1 cycle after the address;
  - stage P registers the LANES signed products and sums them in an adder tree;
  - stage A adds the sum into acc;
  - acc clears on the first word of each neuron (load, not add).
- DRAIN: 2 cycles for the last word to reach acc → WRITE.
- WRITE (1 cycle):
  - out_we=1, out_addr = o_base+n, out_data = Q(acc);
  - n++;
  - if n == out_len → FINISH, else → ISSUE.
- Q(acc):
  - t = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift;
  - saturate t to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1];
  - if relu_en and t<0 then t=0.
- FINISH: done=1 for one cycle; busy=0 in the same cycle → IDLE.
- Cycle cost per neuron: in_len+3; layer latency from start to done = out_len*(in_len+3)+2.
- Address arithmetic wraps modulo 2^width; no error flag.
- Accumulator overflow wraps; preventing it is the responsibility of the ACC_WIDTH sizing.
- Reset mid-layer: abort immediately; no done, no further writes.
- out_we is never high outside WRITE.

Optional Feature:
- Macro: FC_BIAS_EN.
- Defined:
  - adds ports b_raddr (out, ADDR_WIDTH) and b_rdata (in, ACC_WIDTH) plus b_base (in, ADDR_WIDTH);
  - b_raddr = b_base+n is issued alongside k=0;
  - acc is loaded with bias + first sum instead of first sum.
- Undefined: ports absent; acc is loaded with first sum only.
- Latency is unchanged in both cases.

Decomposition:
- Package fc_pkg:
  - FSM state enum;
  - SAT_MAX/SAT_MIN functions of DATA_WIDTH;
  - constant PIPE_DEPTH=2;
  - rounding/saturation function fc_quantize.
- One sub-module, fc_mac_lanes: LANES signed multipliers, adder tree and stage-P register.
- FSM, counters, accumulator and quantize logic stay in fc_engine.

Test Plan:
- LANES=20, in_len=1, out_len=1, all act=1, all w=1, shift=0 → one write with out_data=20; done at cycle 6 after start.
- in_len=4, out_len=3, act=127, w=7, shift=0 → 3 writes of 127 (saturated) at o_base..o_base+2; w_raddr runs contiguously 0..11.
- acc=-300 with shift=2, relu_en=0 → out_data=-75; same with relu_en=1 → 0; acc=6, shift=2 → 2 (round-half-up).
- Second start pulse 5 cycles into the layer, and later in_len=0 → first is ignored with result unchanged; second gives done 2 cycles after start with no out_we.
- srstn asserted mid-ISSUE, then a new start → outputs 0 during reset, no done for the aborted layer; next layer produces correct values.
- FC_BIAS_EN, bias=-20, the 20-ones case → out_data=0; b_raddr = b_base+n on the k=0 cycle.
